// File: rtl/io_out_fifo.sv
// Output-side FIFO between the float core's OUT port and external peripherals.
// Write-side drops on full (flagged by sticky ovf); read side is first-word-fall-through valid/ready.
module io_out_fifo #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            out_en,
    input  logic [$clog2(NUIOOU)-1:0]       addr_out,
    input  logic [NBMANT+NBEXPO:0]          data_in,
    output logic                            port_valid,
    input  logic                            port_ready,
    output logic [$clog2(NUIOOU)-1:0]       port_addr,
    output logic [NBMANT+NBEXPO:0]          port_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FDEPTH):0]         count,
    output logic                            ovf,
    input  logic                            ovf_clr
);

    localparam int DW = NBMANT + NBEXPO + 1;
    localparam int AW = $clog2(NUIOOU);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          mem [FDEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            drop;

    // NOTE: full/empty come from the registered count, so port_ready never reaches them combinationally.
    assign full       = (count == CW'(FDEPTH));
    assign empty      = (count == '0);
    assign port_valid = !empty;

    assign pop  = port_valid & port_ready;
    assign push = out_en & (!full | pop);
    assign drop = out_en & full & !pop;

    // Head is forced to zero while empty so stale storage is never exposed.
    assign head      = mem[rd_ptr];
    assign port_addr = empty ? '0 : head.addr;
    assign port_data = empty ? '0 : head.data;

    // NOTE: storage has no reset; only pointers and count are cleared, which is enough to discard entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: addr_out, data: data_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            // Pointers wrap naturally at FDEPTH because FDEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed bench for io_out_fifo: stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares every accepted head entry.
module tb_io_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_en;
    logic [2:0]  addr_out;
    logic [22:0] data_in;
    logic        port_valid;
    logic        port_ready;
    logic [2:0]  port_addr;
    logic [22:0] port_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        ovf;
    logic        ovf_clr;

    int compared   = 0;
    int mismatched = 0;

    logic [25:0] sb[$];

    io_out_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .out_en     (out_en),
        .addr_out   (addr_out),
        .data_in    (data_in),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .port_addr  (port_addr),
        .port_data  (port_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [22:0] d, input bit accept);
        out_en   = 1'b1;
        addr_out = a;
        data_in  = d;
        if (accept) sb.push_back({a, d});
        cycle();
        out_en   = 1'b0;
    endtask

    // Every entry the peripheral accepts must be the oldest one the bench expects.
    always @(negedge clk) begin
        if (rst && port_valid && port_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected: got addr %0d data 0x%0h, expected no entry", port_addr, port_data);
            end else begin
                logic [25:0] e;
                e = sb.pop_front();
                check("sb_addr", 32'(port_addr), 32'(e[25:23]));
                check("sb_data", 32'(port_data), 32'(e[22:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held with out_en high
        rst = 1'b0; out_en = 1'b1; addr_out = 3'd1; data_in = 23'h7;
        port_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) cycle();
        check("rst_valid", 32'(port_valid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf",   32'(ovf), 0);
        check("rst_addr",  32'(port_addr), 0);
        check("rst_data",  32'(port_data), 0);
        out_en = 1'b0;
        rst = 1'b1;
        repeat (2) cycle();
        check("post_rst_empty", 32'(empty), 1);
        check("post_rst_count", 32'(count), 0);

        // 2: single pass
        wr(3'd3, 23'h12345, 1'b1);
        check("single_valid", 32'(port_valid), 1);
        check("single_addr",  32'(port_addr), 3);
        check("single_data",  32'(port_data), 32'h12345);
        check("single_count", 32'(count), 1);
        port_ready = 1'b1;
        cycle();
        check("single_empty", 32'(empty), 1);
        // write into empty with ready high: no pop on the write edge
        wr(3'd2, 23'h00abc, 1'b1);
        check("empty_rdy_count", 32'(count), 1);
        cycle();
        check("empty_rdy_drained", 32'(empty), 1);
        port_ready = 1'b0;

        // 3: fill and drain in order, head stable while stalled
        for (int i = 1; i <= 4; i++) wr(3'(i + 2), 23'(i), 1'b1);
        check("fill_full",  32'(full), 1);
        check("fill_count", 32'(count), 4);
        check("stall_data0", 32'(port_data), 1);
        cycle();
        check("stall_data1", 32'(port_data), 1);
        check("stall_addr1", 32'(port_addr), 3);
        port_ready = 1'b1;
        repeat (4) cycle();
        check("drain_empty", 32'(empty), 1);
        port_ready = 1'b0;

        // 4: overflow and sticky ovf
        for (int i = 0; i < 4; i++) wr(3'(i), 23'(10 + i), 1'b1);
        wr(3'd7, 23'd9, 1'b0);
        check("ovf_set",   32'(ovf), 1);
        check("ovf_count", 32'(count), 4);
        ovf_clr = 1'b1;
        wr(3'd7, 23'd9, 1'b0);
        check("ovf_set_wins", 32'(ovf), 1);
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);
        check("ovf_count2",  32'(count), 4);
        port_ready = 1'b1;
        repeat (4) cycle();
        check("ovf_drain_empty", 32'(empty), 1);
        port_ready = 1'b0;

        // 5: full with simultaneous pop/push, then sustained wrap
        for (int i = 0; i < 4; i++) wr(3'(i + 1), 23'(20 + i), 1'b1);
        port_ready = 1'b1;
        wr(3'd5, 23'd5, 1'b1);
        check("simul_count", 32'(count), 4);
        check("simul_full",  32'(full), 1);
        check("simul_ovf",   32'(ovf), 0);
        for (int i = 0; i < 12; i++) begin
            wr(3'(i), 23'(23'h100 + i * 23'h111), 1'b1);
            check("wrap_count", 32'(count), 4);
        end
        repeat (4) cycle();
        check("wrap_empty", 32'(empty), 1);
        port_ready = 1'b0;

        // 6: async reset mid-drain
        for (int i = 0; i < 3; i++) wr(3'(i), 23'(30 + i), 1'b1);
        check("pre_rst_count", 32'(count), 3);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_valid", 32'(port_valid), 0);
        check("async_count", 32'(count), 0);
        check("async_empty", 32'(empty), 1);
        cycle();
        rst = 1'b1;
        cycle();
        wr(3'd6, 23'h3abcd, 1'b1);
        check("rerun_valid", 32'(port_valid), 1);
        check("rerun_addr",  32'(port_addr), 6);
        check("rerun_data",  32'(port_data), 32'h3abcd);
        port_ready = 1'b1;
        cycle();
        port_ready = 1'b0;
        check("rerun_empty", 32'(empty), 1);
        check("sb_left", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
